// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default width,
// and the bit-counter width helper.
package serial_subtractor_pkg;

  localparam int D_N_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must index 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: x - y - bin, producing the difference bit and borrow-out.
module full_subtractor (
  input  logic w_x,
  input  logic w_y,
  input  logic w_bin,
  output logic w_d,
  output logic w_bout
);

  assign w_d    = w_x ^ w_y ^ w_bin;
  assign w_bout = (~w_x & w_y) | (~(w_x ^ w_y) & w_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, w_d = w_a - w_b, LSB first, start/done handshake.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the registered signed-overflow output w_ovf.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int D_N = D_N_DEF
) (
  input  logic           w_clk,
  input  logic           w_rst_n,
  input  logic           w_start,
  input  logic [D_N-1:0] w_a,
  input  logic [D_N-1:0] w_b,
  output logic           w_busy,
  output logic           w_done,
  output logic [D_N-1:0] w_d,
  output logic           w_borrow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic           w_ovf
`endif
);

  localparam int CW = cnt_w(D_N);
  localparam logic [CW-1:0] LAST = CW'(D_N - 1);

  state_t         state;
  logic [D_N-1:0] ra, rb;
  logic [CW-1:0]  cnt;
  logic           br;
  logic           d_bit, br_next;

  full_subtractor u_fs (
    .w_x   (ra[0]),
    .w_y   (rb[0]),
    .w_bin (br),
    .w_d   (d_bit),
    .w_bout(br_next)
  );

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  // Operand sign bits are shifted out of ra/rb, so keep a copy for the overflow test.
  logic a_sgn, b_sgn;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      a_sgn <= 1'b0;
      b_sgn <= 1'b0;
      w_ovf <= 1'b0;
    end else begin
      if ((state == ST_IDLE || state == ST_DONE) && w_start) begin
        a_sgn <= w_a[D_N-1];
        b_sgn <= w_b[D_N-1];
      end
      if (state == ST_SHIFT && cnt == LAST)
        w_ovf <= (a_sgn != b_sgn) && (d_bit != a_sgn);
    end
  end
`endif

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state    <= ST_IDLE;
      ra       <= '0;
      rb       <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      w_busy   <= 1'b0;
      w_done   <= 1'b0;
      w_d      <= '0;
      w_borrow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          w_done <= 1'b0;
          if (w_start) begin
            ra     <= w_a;
            rb     <= w_b;
            br     <= 1'b0;
            cnt    <= '0;
            w_busy <= 1'b1;
            state  <= ST_SHIFT;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // Result fills from the MSB side so it is aligned after D_N shifts.
          w_d <= {d_bit, w_d[D_N-1:1]};
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          br  <= br_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            w_borrow <= br_next;
            w_busy   <= 1'b0;
            w_done   <= 1'b1;
            state    <= ST_DONE;
          end
        end
        default: begin
          w_busy <= 1'b0;
          w_done <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (D_N=5): latency, handshake, hold and reset behaviour.
module tb_serial_subtractor;

  localparam int N = 5;

  typedef struct {
    logic [N-1:0] d;
    logic         b;
    logic         o;
  } exp_t;

  logic         w_clk = 1'b0;
  logic         w_rst_n = 1'b0;
  logic         w_start = 1'b0;
  logic [N-1:0] w_a = '0, w_b = '0;
  logic         w_busy, w_done, w_borrow;
  logic [N-1:0] w_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic         w_ovf;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 w_clk = ~w_clk;

  serial_subtractor #(.D_N(N)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_start (w_start),
    .w_a     (w_a),
    .w_b     (w_b),
    .w_busy  (w_busy),
    .w_done  (w_done),
    .w_d     (w_d),
    .w_borrow(w_borrow)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .w_ovf   (w_ovf)
`endif
  );

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  // Expected d/borrow come from the test plan; overflow from the signed definition.
  task automatic push_exp(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] d, input logic bo);
    exp_t e;
    e.d = d;
    e.b = bo;
    e.o = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
    sb.push_back(e);
  endtask

  // Called just after the accepting edge; stops on the sample where w_done is high.
  task automatic wait_check(input string nm, input bit chk_busy);
    int   lat = 0;
    int   bc = 0;
    exp_t e;
    while (!w_done && lat < 40) begin
      if (w_busy) bc++;
      step();
      lat++;
    end
    n_cmp++;
    if (lat != N) begin
      n_bad++;
      $display("FAIL %s latency: got %0d edges, want %0d", nm, lat, N);
    end
    if (chk_busy) begin
      n_cmp++;
      if (bc != N) begin
        n_bad++;
        $display("FAIL %s busy_cycles: got %0d, want %0d", nm, bc, N);
      end
    end
    if (!w_done) return;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard: done with empty queue, got d=%0d", nm, w_d);
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (w_d !== e.d) begin
      n_bad++;
      $display("FAIL %s d: got %0d, want %0d", nm, w_d, e.d);
    end
    n_cmp++;
    if (w_borrow !== e.b) begin
      n_bad++;
      $display("FAIL %s borrow: got %b, want %b", nm, w_borrow, e.b);
    end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    n_cmp++;
    if (w_ovf !== e.o) begin
      n_bad++;
      $display("FAIL %s ovf: got %b, want %b", nm, w_ovf, e.o);
    end
`endif
  endtask

  task automatic run_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] d, input logic bo);
    w_a = a; w_b = b; w_start = 1'b1;
    push_exp(a, b, d, bo);
    step();
    w_start = 1'b0;
    wait_check(nm, 1'b1);
    step();
    n_cmp++;
    if (w_done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_pulse: got %b one cycle later, want 0", nm, w_done);
    end
  endtask

  task automatic test_reset();
    w_rst_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({w_busy, w_done, w_borrow, w_d} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b borrow=%b d=%0d, want all 0",
               w_busy, w_done, w_borrow, w_d);
    end
    w_rst_n = 1'b1;
    step();
    n_cmp++;
    if (w_busy !== 1'b0 || w_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0/0", w_busy, w_done);
    end
  endtask

  task automatic test_basic();
    run_op("basic_20_7", 5'd20, 5'd7, 5'd13, 1'b0);
  endtask

  task automatic test_underflow();
    run_op("uf_7_20", 5'd7, 5'd20, 5'd19, 1'b1);
    run_op("uf_0_1", 5'd0, 5'd1, 5'd31, 1'b1);
  endtask

  task automatic test_equal_hold();
    run_op("eq_31_31", 5'd31, 5'd31, 5'd0, 1'b0);
    run_op("eq_0_0", 5'd0, 5'd0, 5'd0, 1'b0);
    run_op("prep_20_7", 5'd20, 5'd7, 5'd13, 1'b0);
    w_a = 5'd1; w_b = 5'd2;
    repeat (3) step();
    n_cmp++;
    if (w_d !== 5'd13 || w_borrow !== 1'b0 || w_done !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_idle: got d=%0d borrow=%b done=%b, want 13/0/0", w_d, w_borrow, w_done);
    end
  endtask

  task automatic test_signed_ovf();
    run_op("ovf_16_1", 5'd16, 5'd1, 5'd15, 1'b0);
    run_op("ovf_15_31", 5'd15, 5'd31, 5'd16, 1'b1);
  endtask

  task automatic test_back_to_back();
    w_a = 5'd9; w_b = 5'd4; w_start = 1'b1;
    push_exp(5'd9, 5'd4, 5'd5, 1'b0);
    step();
    w_a = 5'd12; w_b = 5'd3;
    push_exp(5'd12, 5'd3, 5'd9, 1'b0);
    wait_check("hs_first", 1'b1);
    step();
    w_start = 1'b0;
    n_cmp++;
    if (w_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL hs_restart: got busy=%b after DONE edge with start high, want 1", w_busy);
    end
    wait_check("hs_second", 1'b1);
    step();
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    w_a = 5'd9; w_b = 5'd4; w_start = 1'b1;
    step();
    w_start = 1'b0;
    repeat (2) step();
    w_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({w_busy, w_done, w_borrow, w_d} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_async: got busy=%b done=%b borrow=%b d=%0d, want all 0",
               w_busy, w_done, w_borrow, w_d);
    end
    repeat (2) step();
    w_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (w_done || w_busy) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_bad++;
      $display("FAIL rst_mid_idle: got done/busy activity after reset, want none");
    end
    run_op("rst_3_1", 5'd3, 5'd1, 5'd2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_equal_hold();
    test_signed_ovf();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
